// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package cache_pkg;
    localparam int TAG_W     = 3;
    localparam int IDX_W     = 3;
    localparam int OFF_W     = 2;
    localparam int BLK_W     = 32;
    localparam int ADDR_BITS = TAG_W + IDX_W + OFF_W;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} dc_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_BITS-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_BITS-1:0] a);
        return a[OFF_W-1:0];
    endfunction
endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: async read by index, sync byte write or full-line fill.
module dcache_line_store import cache_pkg::*; #(
    parameter int LINES       = 8,
    parameter int DATA_W      = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [IDX_W-1:0]                    rd_idx,
    output logic                                rd_valid,
    output logic                                rd_dirty,
    output logic [TAG_W-1:0]                    rd_tag,
    output logic [BLOCK_BYTES-1:0][DATA_W-1:0]  rd_data,
    input  logic [IDX_W-1:0]                    wr_idx,
    input  logic                                byte_we,
    input  logic [OFF_W-1:0]                    byte_off,
    input  logic [DATA_W-1:0]                   byte_data,
    input  logic                                fill_we,
    input  logic [TAG_W-1:0]                    fill_tag,
    input  logic [BLOCK_BYTES-1:0][DATA_W-1:0]  fill_data
);
    logic [LINES-1:0]                               valid_q;
    logic [LINES-1:0]                               dirty_q;
    logic [LINES-1:0][TAG_W-1:0]                    tag_q;
    logic [LINES-1:0][BLOCK_BYTES-1:0][DATA_W-1:0]  data_q;

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Only valid/dirty need clearing; tag and data are meaningless until a fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
            tag_q[wr_idx]   <= fill_tag;
            data_q[wr_idx]  <= fill_data;
        end else if (byte_we) begin
            dirty_q[wr_idx]           <= 1'b1;
            data_q[wr_idx][byte_off]  <= byte_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate cache controller: hit logic, CPU stall and
// the IDLE/WRITE_BACK/MEM_READ/UPDATE miss FSM.
module dcache_controller import cache_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int LINES       = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        writedata,
    output logic [DATA_W-1:0]        readdata,
    output logic                     busywait,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [TAG_W+IDX_W-1:0]   mem_address,
    output logic [BLK_W-1:0]         mem_writedata,
    input  logic [BLK_W-1:0]         mem_readdata,
    input  logic                     mem_busywait
);
    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;

    dc_state_t        state_q, state_d;
    logic             first_q, first_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [BLOCK_BYTES-1:0][DATA_W-1:0] fill_q, fill_d;

    logic                               line_valid, line_dirty;
    logic [TAG_W-1:0]                   line_tag;
    logic [BLOCK_BYTES-1:0][DATA_W-1:0] line_data;
    logic [IDX_W-1:0]                   rd_idx, wr_idx;
    logic req, in_idle, hit, byte_we, fill_we;

    assign a_tag   = addr_tag(address);
    assign a_idx   = addr_idx(address);
    assign a_off   = addr_off(address);
    assign req     = read | write;
    assign in_idle = (state_q == IDLE);

    // Outside IDLE the array is steered to the latched miss line so the victim
    // stays visible for write-back even if the CPU address moves.
    assign rd_idx  = in_idle ? a_idx : miss_idx_q;
    assign wr_idx  = (state_q == UPDATE) ? miss_idx_q : a_idx;
    assign hit     = line_valid && (line_tag == a_tag);
    assign byte_we = RESET && in_idle && write && hit;
    assign fill_we = RESET && (state_q == UPDATE);

    dcache_line_store #(
        .LINES       (LINES),
        .DATA_W      (DATA_W),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_store (
        .clk       (CLK),
        .rst_n     (RESET),
        .rd_idx    (rd_idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_idx    (wr_idx),
        .byte_we   (byte_we),
        .byte_off  (a_off),
        .byte_data (writedata),
        .fill_we   (fill_we),
        .fill_tag  (miss_tag_q),
        .fill_data (fill_q)
    );

    // first_q marks the entry cycle of a memory state, which may never be the exit.
    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        fill_d     = fill_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_tag_d = a_tag;
                    miss_idx_d = a_idx;
                    first_d    = 1'b1;
                    state_d    = (line_valid && line_dirty) ? WRITE_BACK : MEM_READ;
                end
            end
            WRITE_BACK: begin
                if (!first_q && !mem_busywait) begin
                    first_d = 1'b1;
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                if (!first_q && !mem_busywait) begin
                    fill_d  = mem_readdata;
                    state_d = UPDATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            first_q    <= 1'b0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            fill_q     <= fill_d;
        end
    end

    always_comb begin
        busywait      = RESET && req && !(in_idle && hit);
        mem_read      = RESET && (state_q == MEM_READ);
        mem_write     = RESET && (state_q == WRITE_BACK);
        readdata      = RESET ? line_data[a_off] : '0;
        mem_address   = '0;
        mem_writedata = '0;
        if (RESET) begin
            if (state_q == WRITE_BACK) begin
                mem_address   = {line_tag, miss_idx_q};
                mem_writedata = line_data;
            end else if (state_q == MEM_READ) begin
                mem_address   = {miss_tag_q, miss_idx_q};
            end
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench: stimulus queues expected memory/CPU events, a negedge monitor
// reconstructs events from the DUT outputs and compares them in order.
module tb_dcache_controller;
    localparam logic [1:0] K_CPU_RD = 2'd0;
    localparam logic [1:0] K_CPU_WR = 2'd1;
    localparam logic [1:0] K_MRD    = 2'd2;
    localparam logic [1:0] K_MWR    = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [15:0] cyc;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 CLK = ~CLK;

    // Block memory: byte at address a defaults to a; ops take mem_lat busy cycles
    // and the model ignores the strobe for one cycle after completing.
    logic [31:0] mem [64];
    logic [63:0] written = '0;
    int          mem_lat = 1;
    int          cnt = 0;
    logic        busy = 1'b0, done = 1'b0, op_wr = 1'b0;
    logic [5:0]  op_addr = '0;
    logic [31:0] op_data = '0;
    assign mem_busywait = busy;

    function automatic logic [31:0] dflt(input logic [5:0] b);
        logic [7:0] base;
        base = {b, 2'b00};
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    always @(posedge CLK) begin
        if (done) begin
            done <= 1'b0;
        end else if (busy) begin
            if (cnt == 1) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (op_wr) begin
                    mem[op_addr]     <= op_data;
                    written[op_addr] <= 1'b1;
                end else begin
                    mem_readdata <= written[op_addr] ? mem[op_addr] : dflt(op_addr);
                end
            end
            cnt <= cnt - 1;
        end else if (mem_read || mem_write) begin
            busy    <= 1'b1;
            cnt     <= mem_lat;
            op_addr <= mem_address;
            op_wr   <= mem_write;
            op_data <= mem_writedata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] a,
                             input logic [31:0] d, input int c);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.cyc  = c[15:0];
        exp_q.push_back(e);
    endtask

    task automatic score(input ev_t got);
        ev_t want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h cyc=%0d",
                     got.kind, got.addr, got.data, got.cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                         got.kind, got.addr, got.data, got.cyc,
                         want.kind, want.addr, want.data, want.cyc);
            end
        end
    endtask

    // Monitor: strobe bursts are reported when they end, CPU requests when busywait drops.
    int         stall = 0, rd_cnt = 0, wr_cnt = 0;
    logic [7:0] wb_a = '0, rd_a = '0;
    logic [31:0] wb_d = '0;
    always @(negedge CLK) begin
        if (RESET !== 1'b1) begin
            stall  = 0;
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_write) begin
                if (wr_cnt == 0) begin
                    wb_a = {2'b00, mem_address};
                    wb_d = mem_writedata;
                end
                wr_cnt++;
            end else if (wr_cnt > 0) begin
                score('{K_MWR, wb_a, wb_d, wr_cnt[15:0]});
                wr_cnt = 0;
            end
            if (mem_read) begin
                if (rd_cnt == 0) rd_a = {2'b00, mem_address};
                rd_cnt++;
            end else if (rd_cnt > 0) begin
                score('{K_MRD, rd_a, 32'h0, rd_cnt[15:0]});
                rd_cnt = 0;
            end
            if (read || write) begin
                if (busywait) begin
                    stall++;
                end else begin
                    if (write) score('{K_CPU_WR, address, 32'h0, stall[15:0]});
                    else       score('{K_CPU_RD, address, {24'h0, readdata}, stall[15:0]});
                    stall = 0;
                end
            end
        end
    end

    // Entered and left at posedge+1: holds the request until busywait is seen low.
    task automatic cpu_op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        read = r; write = w; address = a; writedata = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (!busywait) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        read = 1'b0; write = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: addr %h still stalled after 100 cycles", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        RESET = 1'b0; read = 1'b1; write = 1'b0; address = 8'h14; writedata = 8'h00;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_busywait", {31'h0, busywait}, 32'h0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_readdata", {24'h0, readdata}, 32'h0);
        chk("rst_mem_address", {26'h0, mem_address}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b1; read = 1'b0;
        @(posedge CLK); #1;

        // Clean read miss, then hits
        expect_ev(K_MRD, 8'h05, 32'h0, 3);
        expect_ev(K_CPU_RD, 8'h14, 32'h14, 5);
        cpu_op(1'b1, 1'b0, 8'h14, 8'h00);
        expect_ev(K_CPU_RD, 8'h15, 32'h15, 0);
        cpu_op(1'b1, 1'b0, 8'h15, 8'h00);
        expect_ev(K_CPU_WR, 8'h16, 32'h0, 0);
        cpu_op(1'b0, 1'b1, 8'h16, 8'hAB);
        expect_ev(K_CPU_RD, 8'h16, 32'hAB, 0);
        cpu_op(1'b1, 1'b0, 8'h16, 8'h00);

        // Dirty conflict miss: write-back of block 5 then refill of block 0x0D
        expect_ev(K_MWR, 8'h05, 32'h17AB1514, 3);
        expect_ev(K_MRD, 8'h0D, 32'h0, 3);
        expect_ev(K_CPU_RD, 8'h34, 32'h34, 8);
        cpu_op(1'b1, 1'b0, 8'h34, 8'h00);

        // Slow memory: mem_read held through five busy cycles
        mem_lat = 5;
        expect_ev(K_MRD, 8'h16, 32'h0, 7);
        expect_ev(K_CPU_RD, 8'h58, 32'h58, 9);
        cpu_op(1'b1, 1'b0, 8'h58, 8'h00);
        mem_lat = 1;

        // Write-allocate miss, then read back
        expect_ev(K_MRD, 8'h20, 32'h0, 3);
        expect_ev(K_CPU_WR, 8'h81, 32'h0, 5);
        cpu_op(1'b0, 1'b1, 8'h81, 8'hCD);
        expect_ev(K_CPU_RD, 8'h81, 32'hCD, 0);
        cpu_op(1'b1, 1'b0, 8'h81, 8'h00);
        expect_ev(K_CPU_RD, 8'h83, 32'h83, 0);
        cpu_op(1'b1, 1'b0, 8'h83, 8'h00);

        // read and write together behave as a write
        expect_ev(K_CPU_WR, 8'h82, 32'h0, 0);
        cpu_op(1'b1, 1'b1, 8'h82, 8'h5A);
        expect_ev(K_CPU_RD, 8'h82, 32'h5A, 0);
        cpu_op(1'b1, 1'b0, 8'h82, 8'h00);

        // Dirty line 5, start a write-back, then reset in the middle of it
        expect_ev(K_CPU_WR, 8'h35, 32'h0, 0);
        cpu_op(1'b0, 1'b1, 8'h35, 8'h11);
        read = 1'b1; address = 8'h94;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (mem_write) begin
                seen = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        chk("wb_started", {31'h0, seen}, 32'h1);
        @(posedge CLK); #1;
        RESET = 1'b0; read = 1'b0;
        @(negedge CLK);
        chk("rst_mid_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_mid_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_mid_writedata", mem_writedata, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("post_rst_mem_write", {31'h0, mem_write}, 32'h0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        // Valid bits were cleared, so this misses cleanly (no write-back)
        expect_ev(K_MRD, 8'h05, 32'h0, 3);
        expect_ev(K_CPU_RD, 8'h16, 32'hAB, 5);
        cpu_op(1'b1, 1'b0, 8'h16, 8'h00);

        repeat (5) @(posedge CLK);
        chk("events_outstanding", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
